// File: rtl/mii_rx_elastic_pkg.sv
// Shared types for the MII receive elastic buffer: FSM states and the
// buffered nibble format.
package mii_rx_elastic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } rx_state_e;

    typedef struct packed {
        logic       err;
        logic [3:0] data;
    } nib_t;

    localparam nib_t NIB_IDLE    = '{err: 1'b0, data: 4'h0};
    localparam nib_t NIB_UNDERRUN = '{err: 1'b1, data: 4'h0};

endpackage

// File: rtl/mii_rx_elastic_fifo.sv
// Nibble FIFO with occupancy count; mark_err poisons the newest entry
// when an incoming nibble had to be dropped.
module nibble_fifo
    import mii_rx_elastic_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  nib_t        wr_data,
    input  logic        rd_en,
    input  logic        mark_err,
    output nib_t        rd_data,
    output logic [AW:0] count,
    output logic        full,
    output logic        empty
);

    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    nib_t            mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr, last_ptr;
    logic            do_wr, do_rd;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_wr    = wr_en && !full;
    assign do_rd    = rd_en && !empty;
    assign last_ptr = wr_ptr - PTR_ONE;
    assign rd_data  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= wr_data;
        else if (mark_err && !empty)
            mem[last_ptr].err <= 1'b1;
    end

endmodule

// File: rtl/mii_rx_elastic.sv
// Re-times jittery PCS receive nibbles onto an evenly spaced MII nibble
// strobe through a small elastic buffer with prefill.
module mii_rx_elastic
    import mii_rx_elastic_pkg::*;
#(
    parameter int CE_DIV  = 5,
    parameter int DEPTH   = 8,
    parameter int PREFILL = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_ce,
    input  logic       in_valid,
    input  logic       in_err,
    input  logic [3:0] in_data,
    output logic       ce,
    output logic       valid,
    output logic       err,
    output logic [3:0] data,
    output logic       overflow,
    output logic       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

    logic [DW-1:0] div;
    rx_state_e     state;
    logic          ended;
    nib_t          rd_data;
    logic [AW:0]   count;
    logic          full, empty;
    logic          wr_req, accept, drop_full, fill_go, pop, pop_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        div <= '0;
        else if (div == DW'(CE_DIV - 1))   div <= '0;
        else                               div <= div + 1'b1;
    end

    assign ce = (div == DW'(CE_DIV - 1));

    // A new frame arriving while the previous one drains is refused outright.
    assign wr_req    = in_ce && in_valid;
    assign accept    = wr_req && (state != ST_DRAIN);
    assign drop_full = accept && full;
    assign fill_go   = (count >= (AW+1)'(PREFILL)) || ended;
    assign pop_state = (state == ST_RUN) || (state == ST_DRAIN) ||
                       ((state == ST_FILL) && fill_go);
    assign pop       = ce && !empty && pop_state;

    nibble_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (accept),
        .wr_data  ('{err: in_err, data: in_data}),
        .rd_en    (pop),
        .mark_err (drop_full),
        .rd_data  (rd_data),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ended     <= 1'b0;
            valid     <= 1'b0;
            err       <= 1'b0;
            data      <= 4'h0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (wr_req && state == ST_DRAIN) || drop_full;
            underflow <= 1'b0;
            if (in_ce && !in_valid && (state == ST_FILL || state == ST_RUN))
                ended <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (ce) begin
                        valid <= 1'b0;
                        {err, data} <= NIB_IDLE;
                    end
                    if (accept) state <= ST_FILL;
                end
                ST_FILL: begin
                    if (ce) begin
                        if (fill_go) begin
                            state <= ST_RUN;
                            valid <= 1'b1;
                            {err, data} <= rd_data;
                        end else begin
                            valid <= 1'b0;
                            {err, data} <= NIB_IDLE;
                        end
                    end
                end
                ST_RUN, ST_DRAIN: begin
                    if (state == ST_RUN && ended) state <= ST_DRAIN;
                    if (ce) begin
                        if (!empty) begin
                            valid <= 1'b1;
                            {err, data} <= rd_data;
                        end else if (ended) begin
                            valid <= 1'b0;
                            {err, data} <= NIB_IDLE;
                            ended <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            valid     <= 1'b1;
                            {err, data} <= NIB_UNDERRUN;
                            underflow <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mii_rx_elastic.sv
// Randomised bench for mii_rx_elastic: frames are pushed with fixed or
// bounded-jitter spacing and the re-timed nibble stream is scored per frame.
module tb_mii_rx_elastic;

    localparam int CE_DIV  = 5;
    localparam int DEPTH   = 8;
    localparam int PREFILL = 4;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       in_ce = 1'b0, in_valid = 1'b0, in_err = 1'b0;
    logic [3:0] in_data = 4'h0;
    logic       ce, valid, err, overflow, underflow;
    logic [3:0] data;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, n_ovf = 0, n_unf = 0;
    logic       vprev = 1'b0;
    logic [5:0] outq[$];
    int         rise_q[$];
    logic [4:0] sent[$];
    logic [4:0] got[$];
    int         runs, uf_nibs, err_nibs;

    always #4 clk = ~clk;

    mii_rx_elastic #(.CE_DIV(CE_DIV), .DEPTH(DEPTH), .PREFILL(PREFILL)) dut (
        .clk(clk), .rst_n(rst_n), .in_ce(in_ce), .in_valid(in_valid),
        .in_err(in_err), .in_data(in_data), .ce(ce), .valid(valid),
        .err(err), .data(data), .overflow(overflow), .underflow(underflow)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Everything the MII pin driver would see, sampled away from the edge.
    always @(negedge clk) begin
        if (ce) outq.push_back({valid, err, data});
        if (overflow)  n_ovf <= n_ovf + 1;
        if (underflow) n_unf <= n_unf + 1;
        if (valid && !vprev) rise_q.push_back(cyc);
        vprev <= valid;
    end

    task automatic send_nib(input logic [4:0] nib, input int gap);
        in_ce = 1'b1; in_valid = 1'b1; {in_err, in_data} = nib;
        sent.push_back(nib);
        @(negedge clk);
        in_ce = 1'b0; in_valid = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic send_end();
        in_ce = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        in_ce = 1'b0;
    endtask

    // Splits a window of the output stream into real nibbles and underrun fillers.
    function automatic void collect(input int base);
        logic p;
        got.delete(); runs = 0; uf_nibs = 0; err_nibs = 0; p = 1'b0;
        for (int i = base; i < outq.size(); i++) begin
            if (outq[i][5] && !p) runs++;
            p = outq[i][5];
            if (outq[i] == 6'b110000) uf_nibs++;
            else if (outq[i][5]) begin
                got.push_back(outq[i][4:0]);
                if (outq[i][4]) err_nibs++;
            end
        end
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({ce, valid, err, data, overflow, underflow} !== 9'd0) begin
            n_bad++; $display("FAIL reset_outputs: got %b want 0", {ce, valid, err, data, overflow, underflow});
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            n_cmp++;
            if (ce !== ((k % CE_DIV) == CE_DIV - 1)) begin
                n_bad++; $display("FAIL reset_ce_phase k=%0d: got %b want %b", k, ce, (k % CE_DIV) == CE_DIV - 1);
            end
            n_cmp++;
            if ({valid, err, data} !== 6'd0) begin
                n_bad++; $display("FAIL idle_outputs k=%0d: got %b want 0", k, {valid, err, data});
            end
        end
    endtask

    task automatic test_nominal();
        int base, o0, u0, r0, t0, lat;
        @(negedge clk);
        sent.delete(); base = outq.size(); o0 = n_ovf; u0 = n_unf; r0 = rise_q.size();
        t0 = cyc;
        for (int i = 1; i <= 10; i++) send_nib({1'b0, 4'(i)}, 5);
        send_end();
        repeat (100) @(negedge clk);
        #1;
        collect(base);
        n_cmp++;
        if (got.size() !== 10) begin
            n_bad++; $display("FAIL nominal_count: got %0d want 10", got.size());
        end
        for (int i = 0; i < 10 && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== {1'b0, 4'(i + 1)}) begin
                n_bad++; $display("FAIL nominal_data[%0d]: got %h want %h", i, got[i], i + 1);
            end
        end
        n_cmp++;
        if (runs !== 1 || uf_nibs !== 0) begin
            n_bad++; $display("FAIL nominal_shape: runs %0d fillers %0d want 1/0", runs, uf_nibs);
        end
        n_cmp++;
        if (n_ovf - o0 !== 0 || n_unf - u0 !== 0) begin
            n_bad++; $display("FAIL nominal_pulses: ovf %0d unf %0d want 0/0", n_ovf - o0, n_unf - u0);
        end
        n_cmp++;
        if (rise_q.size() <= r0) begin
            n_bad++; $display("FAIL nominal_latency: valid never rose want rise");
        end else begin
            lat = rise_q[r0] - t0;
            if (lat < (PREFILL - 1) * CE_DIV + 1 || lat > (PREFILL + 1) * CE_DIV) begin
                n_bad++; $display("FAIL nominal_latency: got %0d want %0d..%0d", lat, (PREFILL - 1) * CE_DIV + 1, (PREFILL + 1) * CE_DIV);
            end
        end
        n_cmp++;
        if (outq[outq.size() - 1] !== 6'd0) begin
            n_bad++; $display("FAIL nominal_idle_after: got %b want 0", outq[outq.size() - 1]);
        end
    endtask

    task automatic test_jitter();
        for (int f = 0; f < 3; f++) begin
            int base, o0, u0, len, d, g;
            @(negedge clk);
            sent.delete(); base = outq.size(); o0 = n_ovf; u0 = n_unf;
            len = $urandom_range(6, 30); d = 0;
            for (int i = 0; i < len; i++) begin
                do g = $urandom_range(4, 6); while (d + g - 5 > 2 || d + g - 5 < -2);
                d += g - 5;
                send_nib({($urandom_range(0, 7) == 0), 4'($urandom)}, g);
            end
            send_end();
            repeat (120) @(negedge clk);
            #1;
            collect(base);
            n_cmp++;
            if (got != sent) begin
                n_bad++; $display("FAIL jitter_stream f=%0d: got %0d nibbles want %0d (content differs)", f, got.size(), sent.size());
            end
            n_cmp++;
            if (runs !== 1 || uf_nibs !== 0 || n_ovf - o0 !== 0 || n_unf - u0 !== 0) begin
                n_bad++; $display("FAIL jitter_shape f=%0d: runs %0d fillers %0d ovf %0d unf %0d want 1/0/0/0", f, runs, uf_nibs, n_ovf - o0, n_unf - u0);
            end
        end
    endtask

    task automatic test_fast();
        int base, o0, u0, j;
        logic ok;
        @(negedge clk);
        sent.delete(); base = outq.size(); o0 = n_ovf; u0 = n_unf;
        for (int i = 0; i < 64; i++) send_nib({1'b0, 4'($urandom)}, 4);
        send_end();
        repeat (100) @(negedge clk);
        #1;
        collect(base);
        n_cmp++;
        if (n_ovf - o0 < 1) begin
            n_bad++; $display("FAIL fast_overflow: got %0d pulses want >=1", n_ovf - o0);
        end
        n_cmp++;
        if (got.size() + (n_ovf - o0) !== 64) begin
            n_bad++; $display("FAIL fast_conservation: out %0d + dropped %0d want 64", got.size(), n_ovf - o0);
        end
        n_cmp++;
        if (err_nibs < 1 || err_nibs > n_ovf - o0) begin
            n_bad++; $display("FAIL fast_err_mark: got %0d err nibbles want 1..%0d", err_nibs, n_ovf - o0);
        end
        j = 0; ok = 1'b1;
        foreach (got[i]) begin
            while (j < sent.size() && sent[j][3:0] != got[i][3:0]) j++;
            if (j >= sent.size()) ok = 1'b0;
            j++;
        end
        n_cmp++;
        if (ok !== 1'b1 || n_unf - u0 !== 0) begin
            n_bad++; $display("FAIL fast_order: subsequence %b unf %0d want 1/0", ok, n_unf - u0);
        end
    endtask

    task automatic test_slow();
        int base, o0, u0;
        @(negedge clk);
        sent.delete(); base = outq.size(); o0 = n_ovf; u0 = n_unf;
        for (int i = 0; i < 64; i++) send_nib({1'b0, 4'($urandom)}, 6);
        send_end();
        repeat (120) @(negedge clk);
        #1;
        collect(base);
        n_cmp++;
        if (n_unf - u0 < 1) begin
            n_bad++; $display("FAIL slow_underflow: got %0d pulses want >=1", n_unf - u0);
        end
        n_cmp++;
        if (uf_nibs !== n_unf - u0) begin
            n_bad++; $display("FAIL slow_filler: got %0d filler nibbles want %0d", uf_nibs, n_unf - u0);
        end
        n_cmp++;
        if (got != sent) begin
            n_bad++; $display("FAIL slow_stream: got %0d nibbles want %0d (content differs)", got.size(), sent.size());
        end
        n_cmp++;
        if (n_ovf - o0 !== 0 || runs !== 1) begin
            n_bad++; $display("FAIL slow_shape: ovf %0d runs %0d want 0/1", n_ovf - o0, runs);
        end
    endtask

    task automatic test_short();
        int base;
        @(negedge clk);
        sent.delete(); base = outq.size();
        send_nib({1'b0, 4'h7}, 5);
        send_nib({1'b1, 4'hC}, 5);
        send_end();
        repeat (80) @(negedge clk);
        #1;
        collect(base);
        n_cmp++;
        if (got != sent || runs !== 1) begin
            n_bad++; $display("FAIL short_frame: got %0d nibbles runs %0d want 2/1", got.size(), runs);
        end
        n_cmp++;
        if (outq[outq.size() - 1] !== 6'd0) begin
            n_bad++; $display("FAIL short_idle_after: got %b want 0", outq[outq.size() - 1]);
        end
    endtask

    task automatic test_reset_mid();
        int base, r0;
        @(negedge clk);
        sent.delete();
        for (int i = 0; i < 8; i++) send_nib({1'b0, 4'($urandom)}, 5);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ce, valid, err, data, overflow, underflow} !== 9'd0) begin
            n_bad++; $display("FAIL midreset_async: got %b want 0", {ce, valid, err, data, overflow, underflow});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base = outq.size(); r0 = rise_q.size();
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            n_cmp++;
            if (ce !== ((k % CE_DIV) == CE_DIV - 1)) begin
                n_bad++; $display("FAIL midreset_ce_phase k=%0d: got %b want %b", k, ce, (k % CE_DIV) == CE_DIV - 1);
            end
        end
        repeat (60) @(negedge clk);
        #1;
        collect(base);
        n_cmp++;
        if (got.size() !== 0 || uf_nibs !== 0 || rise_q.size() !== r0) begin
            n_bad++; $display("FAIL midreset_stale: got %0d nibbles %0d fillers want 0/0", got.size(), uf_nibs);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_jitter();
        test_fast();
        test_slow();
        test_short();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
